timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_pkg.sv | 18 +
 rtl/timer_channel.sv | 102 ++++++++++
 rtl/timer_bank.sv | 74 +++++++
 tb/tb_timer_bank.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer bank: channel mode encoding and the default
// parameter values used by timer_bank and timer_channel.
// -----------------------------------------------------------------------------
package timer_pkg;

  // Channel operating mode, latched on every start edge.
  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  localparam int DEF_CHANNELS       = 4;
  localparam int DEF_COUNTER_WIDTH  = 8;
  localparam int DEF_PRESCALE_WIDTH = 8;

endpackage : timer_pkg

// File: rtl/timer_channel.sv
// -----------------------------------------------------------------------------
// timer_channel
// One independent down-counting timer channel. It detects a rising edge on
// start, loads the counter, and decrements on each shared prescaler tick.
// One-shot channels stop at zero. Periodic channels reload the latched value
// instead of reaching zero.
//
// Ports
//   clk_in    in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   tick      in   shared prescaler tick (decrement enable)
//   start     in   trigger, rising edge only
//   stop      in   synchronous abort, level-sensitive
//   periodic  in   mode, sampled on a start edge
//   value     in   load / reload value, sampled on a start edge
//   counter   out  current count
//   running   out  combinational, counter non-zero
//   expired   out  registered one-cycle expiry pulse
// -----------------------------------------------------------------------------
module timer_channel
  import timer_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     periodic,
  input  logic [COUNTER_WIDTH-1:0] value,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic                     running,
  output logic                     expired
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  logic                     start_q,   start_d;
  // armed_q is set once start has been seen low after reset, so a start held
  // high through reset is not mistaken for a fresh edge.
  logic                     armed_q,   armed_d;
  logic [COUNTER_WIDTH-1:0] cnt_q,     cnt_d;
  logic [COUNTER_WIDTH-1:0] reload_q,  reload_d;
  mode_e                    mode_q,    mode_d;
  logic                     expired_q, expired_d;
  logic                     start_edge;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    start_d    = start;
    armed_d    = armed_q | ~start;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    mode_d     = mode_q;
    expired_d  = 1'b0;
    start_edge = start & ~start_q & armed_q;

    // Priority: start edge, then stop, then tick-driven decrement. A start
    // edge on the expiry cycle therefore reloads and swallows the pulse.
    if (start_edge) begin
      cnt_d    = value;
      reload_d = value;
      mode_d   = mode_e'(periodic);
    end else if (stop) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != '0)) begin
      if (cnt_q == CNT_ONE) begin
        expired_d = 1'b1;
        cnt_d     = (mode_q == MODE_PERIODIC) ? reload_q : '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      reload_q  <= '0;
      mode_q    <= MODE_ONESHOT;
      expired_q <= 1'b0;
    end else begin
      start_q   <= start_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
    end
  end

  assign counter = cnt_q;
  assign running = (cnt_q != '0);
  assign expired = expired_q;

endmodule : timer_channel

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
// A bank of CHANNELS independent down-counting timers sharing one
// free-running prescaler. The prescaler ticks whenever its count reaches (or
// has overshot) the prescale setting, giving a tick period of prescale+1.
//
// Ports
//   clk_in    in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   [CHANNELS]  per-channel trigger, rising edge only
//   stop      in   [CHANNELS]  per-channel synchronous abort
//   periodic  in   [CHANNELS]  per-channel mode (0 one-shot, 1 auto-reload)
//   value     in   [CHANNELS*COUNTER_WIDTH] load values, channel i at
//                  [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   prescale  in   [PRESCALE_WIDTH] tick divider
//   counter   out  [CHANNELS*COUNTER_WIDTH] current counts, packed as value
//   running   out  [CHANNELS]  counter non-zero (combinational)
//   expired   out  [CHANNELS]  registered one-cycle expiry pulses
// -----------------------------------------------------------------------------
module timer_bank
  import timer_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic                              clk_in,
  input  logic                              reset_n,
  input  logic [CHANNELS-1:0]               start,
  input  logic [CHANNELS-1:0]               stop,
  input  logic [CHANNELS-1:0]               periodic,
  input  logic [CHANNELS*COUNTER_WIDTH-1:0] value,
  input  logic [PRESCALE_WIDTH-1:0]         prescale,
  output logic [CHANNELS*COUNTER_WIDTH-1:0] counter,
  output logic [CHANNELS-1:0]               running,
  output logic [CHANNELS-1:0]               expired
);

  logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic                      tick;

  // Using >= rather than == means lowering prescale below the current count
  // ticks on the next cycle instead of wrapping around the full range.
  always_comb begin
    tick        = (presc_cnt_q >= prescale);
    presc_cnt_d = tick ? '0 : presc_cnt_q + PRESCALE_WIDTH'(1);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    timer_channel #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_channel (
      .clk_in   (clk_in),
      .reset_n  (reset_n),
      .tick     (tick),
      .start    (start[g]),
      .stop     (stop[g]),
      .periodic (periodic[g]),
      .value    (value[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .counter  (counter[g*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .running  (running[g]),
      .expired  (expired[g])
    );
  end

endmodule : timer_bank

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
// Self-checking bench for timer_bank: directed scenarios with hand-derived
// expectations, then randomized traffic compared against a cycle-level
// behavioural model of the timer rules.
// -----------------------------------------------------------------------------
module tb_timer_bank;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int PW = 8;

  logic              clk_in = 1'b0;
  logic              reset_n;
  logic [CH-1:0]     start;
  logic [CH-1:0]     stop;
  logic [CH-1:0]     periodic;
  logic [CH*CW-1:0]  value;
  logic [PW-1:0]     prescale;
  logic [CH*CW-1:0]  counter;
  logic [CH-1:0]     running;
  logic [CH-1:0]     expired;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state: plain integers per channel.
  int m_cnt      [CH];
  int m_reload   [CH];
  bit m_periodic [CH];
  bit m_exp      [CH];
  bit m_last     [CH];  // last start level; 1 right after reset (not yet seen low)
  int m_pcnt;

  timer_bank #(
    .CHANNELS       (CH),
    .COUNTER_WIDTH  (CW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .value    (value),
    .prescale (prescale),
    .counter  (counter),
    .running  (running),
    .expired  (expired)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dut_cnt(input int i);
    return int'(counter[i*CW +: CW]);
  endfunction

  task automatic set_value(input int i, input int v);
    value[i*CW +: CW] = CW'(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i]      = 0;
      m_reload[i]   = 0;
      m_periodic[i] = 1'b0;
      m_exp[i]      = 1'b0;
      m_last[i]     = 1'b1;
    end
    m_pcnt = 0;
  endtask

  // Advance one clock: evaluate the model on the pre-edge inputs, clock the
  // DUT, commit the model, then settle 1 time unit past the edge.
  task automatic cyc();
    bit tick;
    int nc [CH];
    int nr [CH];
    bit np [CH];
    bit ne [CH];
    int npc;
    tick = (m_pcnt >= int'(prescale));
    npc  = tick ? 0 : m_pcnt + 1;
    for (int i = 0; i < CH; i++) begin
      nc[i] = m_cnt[i];
      nr[i] = m_reload[i];
      np[i] = m_periodic[i];
      ne[i] = 1'b0;
      if (start[i] && !m_last[i]) begin
        nc[i] = int'(value[i*CW +: CW]);
        nr[i] = nc[i];
        np[i] = periodic[i];
      end else if (stop[i]) begin
        nc[i] = 0;
      end else if (tick && m_cnt[i] > 0) begin
        if (m_cnt[i] == 1) begin
          ne[i] = 1'b1;
          nc[i] = m_periodic[i] ? m_reload[i] : 0;
        end else begin
          nc[i] = m_cnt[i] - 1;
        end
      end
    end
    @(posedge clk_in);
    if (reset_n) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i]      = nc[i];
        m_reload[i]   = nr[i];
        m_periodic[i] = np[i];
        m_exp[i]      = ne[i];
        m_last[i]     = start[i];
      end
      m_pcnt = npc;
    end
    #1;
  endtask

  task automatic test_reset();
    start    = '0;
    stop     = '0;
    periodic = '0;
    value    = '0;
    prescale = '0;
    reset_n  = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (counter !== '0) begin
      miscompares++;
      $display("FAIL reset_counter got %h exp 0", counter);
    end
    vectors++;
    if (running !== '0) begin
      miscompares++;
      $display("FAIL reset_running got %b exp 0", running);
    end
    vectors++;
    if (expired !== '0) begin
      miscompares++;
      $display("FAIL reset_expired got %b exp 0", expired);
    end
    repeat (2) @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_oneshot();
    prescale    = 8'd0;
    periodic[0] = 1'b0;
    set_value(0, 5);
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    vectors++;
    if (dut_cnt(0) !== 5 || expired[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_load cnt %0d exp 5, expired %b exp 0", dut_cnt(0), expired[0]);
    end
    for (int k = 4; k >= 0; k--) begin
      cyc();
      vectors++;
      if (dut_cnt(0) !== k) begin
        miscompares++;
        $display("FAIL oneshot_count got %0d exp %0d", dut_cnt(0), k);
      end
      vectors++;
      if (expired[0] !== (k == 0)) begin
        miscompares++;
        $display("FAIL oneshot_expired at cnt %0d got %b exp %b", k, expired[0], (k == 0));
      end
    end
    cyc();
    vectors++;
    if (expired[0] !== 1'b0 || dut_cnt(0) !== 0) begin
      miscompares++;
      $display("FAIL oneshot_after got cnt %0d expired %b exp 0/0", dut_cnt(0), expired[0]);
    end
  endtask

  task automatic test_periodic();
    int last_c;
    int pulses;
    last_c      = -1;
    pulses      = 0;
    prescale    = 8'd2;
    periodic[1] = 1'b1;
    set_value(1, 3);
    start[1] = 1'b1;
    cyc();
    start[1]    = 1'b0;
    periodic[1] = 1'b0;  // mode must stay latched from the start edge
    for (int c = 0; c < 40; c++) begin
      cyc();
      vectors++;
      if (running[1] !== 1'b1) begin
        miscompares++;
        $display("FAIL periodic_running cycle %0d got %b exp 1", c, running[1]);
      end
      vectors++;
      if (dut_cnt(1) == 0) begin
        miscompares++;
        $display("FAIL periodic_nonzero cycle %0d got 0 exp 1..3", c);
      end
      if (expired[1] === 1'b1) begin
        if (last_c >= 0) begin
          vectors++;
          if (c - last_c != 9) begin
            miscompares++;
            $display("FAIL periodic_gap got %0d exp 9", c - last_c);
          end
        end
        last_c = c;
        pulses++;
      end
    end
    vectors++;
    if (pulses < 4) begin
      miscompares++;
      $display("FAIL periodic_pulses got %0d exp >=4", pulses);
    end
    stop[1] = 1'b1;
    cyc();
    stop[1] = 1'b0;
    vectors++;
    if (dut_cnt(1) !== 0 || expired[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL periodic_stop got cnt %0d expired %b exp 0/0", dut_cnt(1), expired[1]);
    end
  endtask

  task automatic test_stop();
    int n;
    n           = 0;
    prescale    = 8'd0;
    periodic[2] = 1'b0;
    set_value(2, 10);
    start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    while (dut_cnt(2) != 6 && n < 20) begin
      cyc();
      n++;
    end
    vectors++;
    if (dut_cnt(2) !== 6) begin
      miscompares++;
      $display("FAIL stop_reach6 got %0d exp 6", dut_cnt(2));
    end
    stop[2] = 1'b1;
    cyc();
    vectors++;
    if (dut_cnt(2) !== 0 || expired[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_clear got cnt %0d expired %b exp 0/0", dut_cnt(2), expired[2]);
    end
    start[2] = 1'b1;  // start edge while stop is still held: start wins
    cyc();
    vectors++;
    if (dut_cnt(2) !== 10) begin
      miscompares++;
      $display("FAIL stop_start_priority got %0d exp 10", dut_cnt(2));
    end
    start[2] = 1'b0;
    cyc();
    stop[2] = 1'b0;
    vectors++;
    if (dut_cnt(2) !== 0 || expired[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_reclear got cnt %0d expired %b exp 0/0", dut_cnt(2), expired[2]);
    end
  endtask

  task automatic test_held_start();
    int loads;
    int pulses;
    int load_c;
    int exp_c;
    int prev;
    loads       = 0;
    pulses      = 0;
    load_c      = -1;
    exp_c       = -1;
    prescale    = 8'd0;
    periodic[0] = 1'b0;
    set_value(0, 4);
    prev     = dut_cnt(0);
    start[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (dut_cnt(0) > prev) begin
        loads++;
        load_c = c;
      end
      if (expired[0] === 1'b1) begin
        pulses++;
        exp_c = c;
      end
      prev = dut_cnt(0);
    end
    start[0] = 1'b0;
    vectors++;
    if (loads !== 1) begin
      miscompares++;
      $display("FAIL held_loads got %0d exp 1", loads);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL held_pulses got %0d exp 1", pulses);
    end
    vectors++;
    if (exp_c - load_c !== 4) begin
      miscompares++;
      $display("FAIL held_latency got %0d exp 4", exp_c - load_c);
    end
    cyc();
  endtask

  task automatic test_reset_midcount();
    prescale = 8'd3;
    for (int i = 0; i < CH; i++) begin
      set_value(i, 200);
      periodic[i] = i[0];
    end
    start = '1;
    repeat (10) cyc();
    vectors++;
    if (running !== '1) begin
      miscompares++;
      $display("FAIL midreset_running_before got %b exp 1111", running);
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (counter !== '0 || running !== '0 || expired !== '0) begin
      miscompares++;
      $display("FAIL midreset_immediate got cnt %h run %b exp %b, exp all 0", counter, running, expired);
    end
    repeat (2) @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      vectors++;
      if (counter !== '0 || expired !== '0) begin
        miscompares++;
        $display("FAIL midreset_held_start cycle %0d got cnt %h exp %b, exp 0", c, counter, expired);
      end
    end
    start = '0;
    cyc();
    start = '1;
    cyc();
    for (int i = 0; i < CH; i++) begin
      vectors++;
      if (dut_cnt(i) !== 200) begin
        miscompares++;
        $display("FAIL midreset_reload ch%0d got %0d exp 200", i, dut_cnt(i));
      end
    end
    start = '0;
    stop  = '1;
    cyc();
    stop = '0;
  endtask

  task automatic test_retrigger();
    int n;
    n           = 0;
    prescale    = 8'd0;
    periodic[3] = 1'b0;
    set_value(3, 7);
    start[3] = 1'b1;
    cyc();
    start[3] = 1'b0;
    while (dut_cnt(3) != 1 && n < 20) begin
      cyc();
      n++;
    end
    vectors++;
    if (dut_cnt(3) !== 1) begin
      miscompares++;
      $display("FAIL retrig_reach1 got %0d exp 1", dut_cnt(3));
    end
    start[3] = 1'b1;
    cyc();
    start[3] = 1'b0;
    vectors++;
    if (dut_cnt(3) !== 7 || expired[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL retrig_load got cnt %0d expired %b exp 7/0", dut_cnt(3), expired[3]);
    end
    cyc();
    vectors++;
    if (dut_cnt(3) !== 6) begin
      miscompares++;
      $display("FAIL retrig_continue got %0d exp 6", dut_cnt(3));
    end
  endtask

  task automatic test_random();
    start   = '0;
    stop    = '0;
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) prescale = PW'($urandom_range(0, 4));
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) start[i] = ~start[i];
        stop[i] = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 3) == 0) begin
          periodic[i] = 1'($urandom_range(0, 1));
          set_value(i, int'($urandom_range(0, 9)));
        end
      end
      cyc();
      for (int i = 0; i < CH; i++) begin
        vectors++;
        if (dut_cnt(i) !== m_cnt[i]) begin
          miscompares++;
          $display("FAIL rand_counter cycle %0d ch%0d got %0d exp %0d", c, i, dut_cnt(i), m_cnt[i]);
        end
        vectors++;
        if (running[i] !== (m_cnt[i] != 0)) begin
          miscompares++;
          $display("FAIL rand_running cycle %0d ch%0d got %b exp %b", c, i, running[i], (m_cnt[i] != 0));
        end
        vectors++;
        if (expired[i] !== m_exp[i]) begin
          miscompares++;
          $display("FAIL rand_expired cycle %0d ch%0d got %b exp %b", c, i, expired[i], m_exp[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop();
    test_held_start();
    test_reset_midcount();
    test_retrigger();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_timer_bank
